step_motor_controller_multi: RTL and testbench

STEP_MOTOR_CONTROLLER_MULTI -- requirements
Module: step_motor_controller_multi

---
 rtl/step_motor_controller_multi.sv | 115 +++++++++++
 tb/tb_step_motor_controller_multi.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_motor_controller_multi.sv
// Multi-channel stepper motor sequencer: per-channel phase index, step timer and
// remaining-step counter driving registered 4-phase coil outputs.
module step_motor_controller_multi #(
   parameter int unsigned NB_CH    = 2,
   parameter int unsigned STEP_W   = 16,
   parameter int unsigned PERIOD_W = 16,
   localparam int unsigned CH_W    = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [CH_W-1:0]       cmd_ch,
   input  logic                  cmd_dir,
   input  logic                  cmd_half,
   input  logic [STEP_W-1:0]     cmd_steps,
   input  logic [PERIOD_W-1:0]   cmd_period,
   output logic [NB_CH-1:0]      busy,
   output logic [NB_CH-1:0]      done,
   output logic [4*NB_CH-1:0]    coils
);

   logic [2:0]          phase     [NB_CH];
   logic [STEP_W-1:0]   remaining [NB_CH];
   logic [PERIOD_W-1:0] timer     [NB_CH];
   logic [PERIOD_W-1:0] period    [NB_CH];
   logic [NB_CH-1:0]    half_q;
   logic [NB_CH-1:0]    dir_q;

   logic                ch_valid_c;
   logic [NB_CH-1:0]    sel_c;
   logic [PERIOD_W-1:0] cmd_n_c;
   logic                cmd_zero_c;

   function automatic logic [3:0] coil_pattern(input logic [2:0] p);
      logic [3:0] pat;
      pat = 4'b1000;
      case (p)
         3'd0: pat = 4'b1000;
         3'd1: pat = 4'b1100;
         3'd2: pat = 4'b0100;
         3'd3: pat = 4'b0110;
         3'd4: pat = 4'b0010;
         3'd5: pat = 4'b0011;
         3'd6: pat = 4'b0001;
         3'd7: pat = 4'b1001;
      endcase
      return pat;
   endfunction

   // Handshake: out-of-range channels and stop commands are always taken.
   always_comb begin
      ch_valid_c = 32'(cmd_ch) < NB_CH;
      cmd_zero_c = (cmd_steps == '0);
      cmd_n_c    = (cmd_period == '0) ? PERIOD_W'(1) : cmd_period;
      cmd_ready  = !ch_valid_c || cmd_zero_c || !busy[cmd_ch];
      sel_c      = '0;
      if (cmd_valid && cmd_ready && ch_valid_c)
         sel_c[cmd_ch] = 1'b1;
   end

   // Per-channel motion: an accepted command overrides any step due in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NB_CH; i++) begin
            phase[i]     <= '0;
            remaining[i] <= '0;
            timer[i]     <= '0;
            period[i]    <= '0;
         end
         half_q <= '0;
         dir_q  <= '0;
         busy   <= '0;
         done   <= '0;
         coils  <= '0;
      end else begin
         for (int i = 0; i < NB_CH; i++) begin
            coils[4*i +: 4] <= enable ? coil_pattern(phase[i]) : 4'b0000;
            done[i]         <= 1'b0;
            if (sel_c[i]) begin
               if (cmd_zero_c) begin
                  busy[i] <= 1'b0;
               end else begin
                  busy[i]      <= 1'b1;
                  remaining[i] <= cmd_steps;
                  timer[i]     <= cmd_n_c;
                  period[i]    <= cmd_n_c;
                  half_q[i]    <= cmd_half;
                  dir_q[i]     <= cmd_dir;
                  // Full-step runs on odd indices; align without counting a step.
                  if (!cmd_half && !phase[i][0])
                     phase[i] <= cmd_dir ? phase[i] + 3'd1 : phase[i] - 3'd1;
               end
            end else if (busy[i] && enable) begin
               if (timer[i] == PERIOD_W'(1)) begin
                  timer[i]     <= period[i];
                  remaining[i] <= remaining[i] - STEP_W'(1);
                  if (dir_q[i])
                     phase[i] <= phase[i] + (half_q[i] ? 3'd1 : 3'd2);
                  else
                     phase[i] <= phase[i] - (half_q[i] ? 3'd1 : 3'd2);
                  if (remaining[i] == STEP_W'(1)) begin
                     busy[i] <= 1'b0;
                     done[i] <= 1'b1;
                  end
               end else begin
                  timer[i] <= timer[i] - PERIOD_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_step_motor_controller_multi.sv
// Bench for step_motor_controller_multi: directed scenarios plus random commands,
// checked every cycle against an event-level model of the motor channels.
module tb_step_motor_controller_multi;
   localparam int NB = 3;
   localparam int SW = 8;
   localparam int PW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic enable = 1'b0;
   logic cmd_valid = 1'b0;
   logic cmd_dir = 1'b0;
   logic cmd_half = 1'b0;
   logic [1:0] cmd_ch = '0;
   logic [SW-1:0] cmd_steps = '0;
   logic [PW-1:0] cmd_period = '0;
   logic cmd_ready;
   logic [NB-1:0] busy;
   logic [NB-1:0] done;
   logic [4*NB-1:0] coils;

   int vectors = 0;
   int miscompares = 0;
   bit chk_on = 1'b0;

   step_motor_controller_multi #(.NB_CH(NB), .STEP_W(SW), .PERIOD_W(PW)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_dir(cmd_dir), .cmd_half(cmd_half),
      .cmd_steps(cmd_steps), .cmd_period(cmd_period), .busy(busy), .done(done),
      .coils(coils)
   );

   always #5 clk = ~clk;

   // Reference model: phase as an integer mod 8, steps counted in enabled cycles.
   logic [3:0] table_q [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                               4'b0010, 4'b0011, 4'b0001, 4'b1001};
   int   m_p [NB];
   int   m_rem [NB];
   int   m_n [NB];
   int   m_cnt [NB];
   bit   m_busy [NB];
   bit   m_done [NB];
   bit   m_half [NB];
   bit   m_dir [NB];
   logic [3:0] m_coils [NB];

   function automatic bit model_ready();
      return (int'(cmd_ch) >= NB) || (cmd_steps == '0) || !m_busy[int'(cmd_ch)];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      bit acc;
      int d;
      if (!rst_n) begin
         for (int i = 0; i < NB; i++) begin
            m_p[i] = 0; m_rem[i] = 0; m_n[i] = 1; m_cnt[i] = 0;
            m_busy[i] = 0; m_done[i] = 0; m_half[i] = 0; m_dir[i] = 0;
            m_coils[i] = 4'b0000;
         end
      end else begin
         acc = cmd_valid && model_ready();
         for (int i = 0; i < NB; i++) begin
            m_coils[i] = enable ? table_q[m_p[i]] : 4'b0000;
            m_done[i] = 0;
            if (acc && int'(cmd_ch) == i) begin
               if (cmd_steps == '0) begin
                  m_busy[i] = 0;
               end else begin
                  m_busy[i] = 1;
                  m_rem[i] = int'(cmd_steps);
                  m_n[i] = (cmd_period == '0) ? 1 : int'(cmd_period);
                  m_cnt[i] = 0;
                  m_half[i] = cmd_half;
                  m_dir[i] = cmd_dir;
                  if (!cmd_half && (m_p[i] % 2 == 0))
                     m_p[i] = (m_p[i] + (cmd_dir ? 1 : -1) + 8) % 8;
               end
            end else if (m_busy[i] && enable) begin
               m_cnt[i]++;
               if (m_cnt[i] == m_n[i]) begin
                  m_cnt[i] = 0;
                  d = m_half[i] ? 1 : 2;
                  m_p[i] = (m_p[i] + (m_dir[i] ? d : -d) + 8) % 8;
                  m_rem[i]--;
                  if (m_rem[i] == 0) begin
                     m_busy[i] = 0;
                     m_done[i] = 1;
                  end
               end
            end
         end
      end
   end

   task automatic check(input string nm, input int ch, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s ch%0d at %0t: got %0h expected %0h", nm, ch, $time, act, exp);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_on) begin
         check("cmd_ready", int'(cmd_ch), 32'(cmd_ready), 32'(model_ready()));
         for (int i = 0; i < NB; i++) begin
            check("busy", i, 32'(busy[i]), 32'(m_busy[i]));
            check("done", i, 32'(done[i]), 32'(m_done[i]));
            check("coils", i, 32'(4'(coils >> (4*i))), 32'(m_coils[i]));
         end
      end
   end

   logic [3:0] cap_vals [$];
   int cap_at [$];
   int cap_ndone, cap_nbusy, cap_done_at;

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
   endtask

   task automatic send(input int ch, input bit dir, input bit half, input int steps,
                       input int period);
      cmd_ch = 2'(ch); cmd_dir = dir; cmd_half = half;
      cmd_steps = SW'(steps); cmd_period = PW'(period); cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   // Record coil changes and busy/done activity of one channel over n cycles.
   task automatic capture(input int ch, input int n);
      logic [3:0] prev, cur;
      cap_vals.delete(); cap_at.delete();
      cap_ndone = 0; cap_nbusy = 0; cap_done_at = -1;
      prev = 4'(coils >> (4*ch));
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         cur = 4'(coils >> (4*ch));
         if (cur !== prev) begin
            cap_vals.push_back(cur);
            cap_at.push_back(k);
            prev = cur;
         end
         if (done[ch]) begin cap_ndone++; cap_done_at = k; end
         if (busy[ch]) cap_nbusy++;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      logic [3:0] exp37 [6];
      exp37 = '{4'b1001, 4'b0011, 4'b0110, 4'b1100, 4'b1001, 4'b0011};
      #2;
      rst_n = 1'b0;
      chk_on = 1'b1;
      check("reset_coils", -1, 32'(coils), 32'h0);
      check("reset_busy", -1, 32'(busy), 32'h0);
      check("reset_ready", -1, 32'(cmd_ready), 32'h1);
      idle(2);
      rst_n = 1'b1;
      enable = 1'b1;
      idle(2);

      // Half-step forward, three steps four cycles apart.
      send(0, 1'b1, 1'b1, 3, 4);
      capture(0, 16);
      check("h3_nchanges", 0, 32'(cap_vals.size()), 32'd3);
      if (cap_vals.size() == 3) begin
         check("h3_v0", 0, 32'(cap_vals[0]), 32'b1100);
         check("h3_v1", 0, 32'(cap_vals[1]), 32'b0100);
         check("h3_v2", 0, 32'(cap_vals[2]), 32'b0110);
         check("h3_first_at", 0, 32'(cap_at[0]), 32'd6);
         check("h3_gap1", 0, 32'(cap_at[1] - cap_at[0]), 32'd4);
         check("h3_gap2", 0, 32'(cap_at[2] - cap_at[1]), 32'd4);
      end
      check("h3_ndone", 0, 32'(cap_ndone), 32'd1);
      check("h3_done_at", 0, 32'(cap_done_at), 32'd13);
      check("h3_nbusy", 0, 32'(cap_nbusy), 32'd12);

      // Full-step reverse from p=0, one step per cycle.
      do_reset();
      send(1, 1'b0, 1'b0, 5, 1);
      capture(1, 10);
      check("f5_nchanges", 1, 32'(cap_vals.size()), 32'd6);
      if (cap_vals.size() == 6)
         for (int k = 0; k < 6; k++) check("f5_seq", 1, 32'(cap_vals[k]), 32'(exp37[k]));
      check("f5_nbusy", 1, 32'(cap_nbusy), 32'd5);
      check("f5_ndone", 1, 32'(cap_ndone), 32'd1);
      check("f5_final", 1, 32'(coils[7:4]), 32'b0011);

      // Busy channel refuses new motion but accepts an abort.
      do_reset();
      send(0, 1'b1, 1'b1, 100, 2);
      idle(3);
      cmd_ch = 2'd0; cmd_steps = SW'(5); cmd_valid = 1'b1;
      #1 check("busy_ready", 0, 32'(cmd_ready), 32'h0);
      @(posedge clk); #1;
      cmd_steps = '0;
      #1 check("abort_ready", 0, 32'(cmd_ready), 32'h1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("abort_busy", 0, 32'(busy[0]), 32'h0);
      capture(0, 5);
      check("abort_ndone", 0, 32'(cap_ndone), 32'd0);

      // Enable low freezes motion and blanks the coils.
      do_reset();
      send(0, 1'b1, 1'b1, 6, 3);
      idle(5);
      enable = 1'b0;
      idle(2);
      check("frz_coils", 0, 32'(coils[3:0]), 32'h0);
      idle(8);
      enable = 1'b1;
      capture(0, 30);
      check("frz_ndone", 0, 32'(cap_ndone), 32'd1);
      check("frz_final", 0, 32'(coils[3:0]), 32'b0001);

      // Reset mid-motion on two channels.
      do_reset();
      send(0, 1'b1, 1'b1, 20, 2);
      send(1, 1'b0, 1'b0, 20, 1);
      idle(3);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_coils", -1, 32'(coils), 32'h0);
      check("rst_mid_busy", -1, 32'(busy), 32'h0);
      check("rst_mid_done", -1, 32'(done), 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      capture(1, 6);
      check("rst_ndone", 1, 32'(cap_ndone), 32'd0);
      send(0, 1'b1, 1'b0, 1, 1);
      capture(0, 5);
      check("rst_post_ndone", 0, 32'(cap_ndone), 32'd1);
      if (cap_vals.size() > 0)
         check("rst_post_final", 0, 32'(cap_vals[cap_vals.size()-1]), 32'b0110);

      // Full-range counts and an out-of-range channel.
      do_reset();
      send(2, 1'b1, 1'b1, 255, 1);
      capture(2, 260);
      check("max_steps_busy", 2, 32'(cap_nbusy), 32'd255);
      check("max_steps_done_at", 2, 32'(cap_done_at), 32'd256);
      send(2, 1'b0, 1'b1, 2, 255);
      capture(2, 515);
      check("max_period_busy", 2, 32'(cap_nbusy), 32'd510);
      check("max_period_ndone", 2, 32'(cap_ndone), 32'd1);
      cmd_ch = 2'd3; cmd_steps = SW'(4); cmd_valid = 1'b1;
      #1 check("oor_ready", 3, 32'(cmd_ready), 32'h1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("oor_busy", 3, 32'(busy), 32'h0);

      // Random commands, enables and occasional resets.
      for (int n = 0; n < 3000; n++) begin
         enable     = ($urandom_range(0, 9) != 0);
         cmd_valid  = ($urandom_range(0, 2) == 0);
         cmd_ch     = 2'($urandom_range(0, 3));
         cmd_dir    = 1'($urandom);
         cmd_half   = 1'($urandom);
         cmd_steps  = ($urandom_range(0, 4) == 0) ? '0 : SW'($urandom_range(1, 8));
         cmd_period = PW'($urandom_range(0, 4));
         if ($urandom_range(0, 499) == 0) begin
            #2 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      enable = 1'b1;
      idle(40);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
